// File: rtl/timer_multi.sv
// Multi-channel programmable timer with shared ms/cs/ds/s/min prescaler.
// Optional TIMER_IRQ_MASK_EN adds irq_mask input and registered irq output.
module timer_multi #(
  parameter int NCH    = 2,
  parameter int CHW    = 1,
  parameter int THR_W  = 4,
  parameter int MS_DIV = 20000
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TIMER_IRQ_MASK_EN
  input  logic [NCH-1:0]   irq_mask,
  output logic             irq,
`endif
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [2:0]       wr_base,
  input  logic [THR_W-1:0] wr_umbral,
  input  logic             wr_periodic,
  input  logic             wr_start,
  input  logic             stop_en,
  input  logic [CHW-1:0]   stop_ch,
  input  logic             ack_en,
  input  logic [CHW-1:0]   ack_ch,
  output logic [NCH-1:0]   out_timer,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   running
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } st_t;

  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_ms10;
  logic [3:0]    r_cs10;
  logic [3:0]    r_ds10;
  logic [5:0]    r_s60;

  logic          w_ms;
  logic          w_cs;
  logic          w_ds;
  logic          w_s;
  logic          w_min;
  logic [7:0]    w_tv;

  assign w_ms  = (r_pcnt == PW'(MS_DIV - 1));
  assign w_cs  = w_ms & (r_ms10 == 4'd9);
  assign w_ds  = w_cs & (r_cs10 == 4'd9);
  assign w_s   = w_ds & (r_ds10 == 4'd9);
  assign w_min = w_s & (r_s60 == 6'd59);
  // indexed directly by the base code; codes 5..7 select a dead tick
  assign w_tv  = {3'b000, w_ms, w_cs, w_ds, w_s, w_min};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
      r_ms10 <= '0;
      r_cs10 <= '0;
      r_ds10 <= '0;
      r_s60  <= '0;
    end else begin
      r_pcnt <= w_ms ? '0 : r_pcnt + PW'(1);
      if (w_ms)
        r_ms10 <= (r_ms10 == 4'd9) ? 4'd0 : r_ms10 + 4'd1;
      if (w_cs)
        r_cs10 <= (r_cs10 == 4'd9) ? 4'd0 : r_cs10 + 4'd1;
      if (w_ds)
        r_ds10 <= (r_ds10 == 4'd9) ? 4'd0 : r_ds10 + 4'd1;
      if (w_s)
        r_s60 <= (r_s60 == 6'd59) ? 6'd0 : r_s60 + 6'd1;
    end
  end

  st_t              r_st  [NCH];
  st_t              w_nxt [NCH];
  logic [2:0]       r_base[NCH];
  logic [THR_W-1:0] r_umb [NCH];
  logic [THR_W-1:0] r_cnt [NCH];
  logic [NCH-1:0]   r_per;
  logic [NCH-1:0]   r_out;
  logic [NCH-1:0]   r_pend;

  logic [NCH-1:0]   w_tick;
  logic [NCH-1:0]   w_stop;
  logic [NCH-1:0]   w_wr;
  logic [NCH-1:0]   w_ack;
  logic [NCH-1:0]   w_hit;
  logic [NCH-1:0]   w_exp;
  logic             w_cfg_ok;

  assign w_cfg_ok = wr_start & (wr_base <= 3'd4) & (wr_umbral != '0);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_tick[g]  = w_tv[r_base[g]];
    assign w_stop[g]  = stop_en & (stop_ch == CHW'(g));
    // a stop on the same edge discards the write
    assign w_wr[g]    = wr_en & (wr_ch == CHW'(g)) & ~w_stop[g];
    assign w_ack[g]   = ack_en & (ack_ch == CHW'(g));
    assign w_hit[g]   = (r_st[g] == RUN) & w_tick[g]
                      & ((r_cnt[g] + THR_W'(1)) == r_umb[g]);
    assign w_exp[g]   = w_hit[g] & ~w_wr[g];
    assign running[g] = (r_st[g] == RUN);
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_nxt[i] = r_st[i];
      if (w_stop[i])
        w_nxt[i] = IDLE;
      else if (w_wr[i])
        w_nxt[i] = w_cfg_ok ? RUN : IDLE;
      else if (w_hit[i] && !r_per[i])
        w_nxt[i] = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++)
        r_st[i] <= IDLE;
    end else begin
      for (int i = 0; i < NCH; i++)
        r_st[i] <= w_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_base[i] <= '0;
        r_umb[i]  <= '0;
        r_cnt[i]  <= '0;
      end
      r_per  <= '0;
      r_out  <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_stop[i]) begin
          r_cnt[i] <= '0;
        end else if (w_wr[i]) begin
          r_base[i] <= wr_base;
          r_umb[i]  <= wr_umbral;
          r_per[i]  <= wr_periodic;
          r_cnt[i]  <= '0;
        end else if (r_st[i] == RUN && w_tick[i]) begin
          r_cnt[i] <= w_hit[i] ? '0 : r_cnt[i] + THR_W'(1);
        end
        r_out[i] <= w_exp[i];
        if (w_exp[i])
          r_pend[i] <= 1'b1;
        else if (w_ack[i])
          r_pend[i] <= 1'b0;
      end
    end
  end

  assign out_timer = r_out;
  assign pending   = r_pend;

`ifdef TIMER_IRQ_MASK_EN
  logic r_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_irq <= 1'b0;
    else
      r_irq <= |(r_pend & ~irq_mask);
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: expected expiry pulses are queued
// by the stimulus and matched by a monitor watching out_timer.
module tb_timer_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [0:0] wr_ch = '0;
  logic [2:0] wr_base = '0;
  logic [3:0] wr_umbral = '0;
  logic       wr_periodic = 1'b0;
  logic       wr_start = 1'b0;
  logic       stop_en = 1'b0;
  logic [0:0] stop_ch = '0;
  logic       ack_en = 1'b0;
  logic [0:0] ack_ch = '0;
  logic [1:0] out_timer;
  logic [1:0] pending;
  logic [1:0] running;
`ifdef TIMER_IRQ_MASK_EN
  logic [1:0] irq_mask = '0;
  logic       irq;
`endif

  timer_multi #(
    .NCH(2), .CHW(1), .THR_W(4), .MS_DIV(4)
  ) dut (
    .clk(clk),
    .reset(rst_n),
`ifdef TIMER_IRQ_MASK_EN
    .irq_mask(irq_mask),
    .irq(irq),
`endif
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_base(wr_base),
    .wr_umbral(wr_umbral),
    .wr_periodic(wr_periodic),
    .wr_start(wr_start),
    .stop_en(stop_en),
    .stop_ch(stop_ch),
    .ack_en(ack_en),
    .ack_ch(ack_ch),
    .out_timer(out_timer),
    .pending(pending),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ed;
    logic [1:0] mask;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (rst_n && out_timer != 2'b00) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected edge=%0d got=%b required=none",
                 edge_n, out_timer);
      end else begin
        m_e = q.pop_front();
        if (m_e.ed != edge_n || m_e.mask != out_timer) begin
          n_fail++;
          $display("FAIL pulse got edge=%0d mask=%b required edge=%0d mask=%b",
                   edge_n, out_timer, m_e.ed, m_e.mask);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h required=%0h", nm, edge_n, act, req);
    end
  endtask

  task automatic push(input int e, input logic [1:0] m);
    exp_t x;
    x.ed = e;
    x.mask = m;
    q.push_back(x);
  endtask

  task automatic go(input int e);
    while (edge_n < e - 1) @(negedge clk);
  endtask

  task automatic after(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic wr(input int e, input logic ch, input logic [2:0] b,
                    input logic [3:0] u, input logic p, input logic s);
    go(e);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_base = b;
    wr_umbral = u;
    wr_periodic = p;
    wr_start = s;
    @(negedge clk);
    wr_en = 1'b0;
    wr_start = 1'b0;
  endtask

  task automatic stop(input int e, input logic ch);
    go(e);
    stop_en = 1'b1;
    stop_ch = ch;
    @(negedge clk);
    stop_en = 1'b0;
  endtask

  task automatic ack(input int e, input logic ch);
    go(e);
    ack_en = 1'b1;
    ack_ch = ch;
    @(negedge clk);
    ack_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    stop_en = 1'b0;
    ack_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out", out_timer, 0);
    chk("rst_pend", pending, 0);
    chk("rst_run", running, 0);
  endtask

  initial begin
    // periodic ms, ack collisions
    do_reset();
    push(12, 2'b01);
    push(24, 2'b01);
    wr(1, 1'b0, 3'b100, 4'd3, 1'b1, 1'b1);
    chk("a_run", running, 2'b01);
    chk("a_pend0", pending, 2'b00);
    ack(12, 1'b0);
    chk("a_ack_vs_exp", pending, 2'b01);
    ack(14, 1'b0);
    chk("a_ack_clr", pending, 2'b00);
    after(24);
    chk("a_pend24", pending, 2'b01);
    stop(25, 1'b0);
    chk("a_stop_run", running, 2'b00);
    chk("a_stop_pend", pending, 2'b01);

    // one-shot cs and invalid configs
    do_reset();
    push(40, 2'b10);
    wr(1, 1'b1, 3'b011, 4'd1, 1'b0, 1'b1);
    chk("b_run", running, 2'b10);
    wr(2, 1'b0, 3'b101, 4'd3, 1'b0, 1'b1);
    chk("b_bad_base", running, 2'b10);
    wr(3, 1'b0, 3'b100, 4'd0, 1'b0, 1'b1);
    chk("b_zero_umb", running, 2'b10);
    after(39);
    chk("b_run39", running, 2'b10);
    after(40);
    chk("b_oneshot_run", running, 2'b00);
    chk("b_pend", pending, 2'b10);
    after(85);

    // stop, restart, stop colliding with expiry
    do_reset();
    push(20, 2'b01);
    push(32, 2'b01);
    wr(1, 1'b0, 3'b100, 4'd3, 1'b1, 1'b1);
    stop(9, 1'b0);
    chk("c_stop", running, 2'b00);
    wr(10, 1'b0, 3'b100, 4'd3, 1'b1, 1'b1);
    chk("c_restart", running, 2'b01);
    after(20);
    chk("c_pend20", pending, 2'b01);
    ack(21, 1'b0);
    chk("c_ack", pending, 2'b00);
    stop(32, 1'b0);
    chk("c_stop_exp_run", running, 2'b00);
    chk("c_stop_exp_pend", pending, 2'b01);
    after(46);

    // async reset mid-run
    do_reset();
    push(4, 2'b01);
    push(8, 2'b01);
    wr(1, 1'b0, 3'b100, 4'd1, 1'b1, 1'b1);
    wr(2, 1'b1, 3'b100, 4'd3, 1'b1, 1'b1);
    after(10);
    chk("d_run10", running, 2'b11);
    chk("d_pend10", pending, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("d_async_out", out_timer, 0);
    chk("d_async_pend", pending, 0);
    chk("d_async_run", running, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // prescaler restart, write colliding with expiry
    push(4, 2'b01);
    push(8, 2'b10);
    push(12, 2'b01);
    wr(1, 1'b0, 3'b100, 4'd1, 1'b1, 1'b1);
    wr(2, 1'b1, 3'b100, 4'd2, 1'b1, 1'b1);
    after(4);
    chk("e_pend4", pending, 2'b01);
    ack(6, 1'b0);
    chk("e_ack", pending, 2'b00);
    wr(8, 1'b0, 3'b100, 4'd1, 1'b1, 1'b1);
    chk("e_wr_vs_exp", pending, 2'b10);
    chk("e_run8", running, 2'b11);
    stop(13, 1'b0);
    stop(14, 1'b1);
    chk("e_stopped", running, 2'b00);
    after(20);

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pulse_missing got=%0d_left required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
